// File: rtl/jk_latch_pkg.sv
`timescale 1ns/1ps
// Shared constants for the NAND-style JK latch bank: reset value, default
// gate delay and settle bound (in gate delays) used by JK_LATCH_GATE_DELAY_EN builds.
package jk_latch_pkg;

  localparam logic        Q_RESET            = 1'b0;
  localparam int unsigned DEFAULT_GATE_DELAY = 1;
  localparam int unsigned SETTLE_GATES       = 3;

  function automatic int unsigned settle_time(input int unsigned gate_delay);
    return SETTLE_GATES * gate_delay;
  endfunction

endpackage

// File: rtl/jk_latch_bit.sv
`timescale 1ns/1ps
// One level-sensitive JK latch bit: J/K steering NANDs, a NAND-style SR core with
// asynchronous clear, and an arm flag limiting J=K=1 to one toggle per arm event.
// JK_LATCH_GATE_DELAY_EN adds #GATE_DELAY to every gate.
module jk_latch_bit
  import jk_latch_pkg::*;
`ifdef JK_LATCH_GATE_DELAY_EN
  #(
    parameter int unsigned GATE_DELAY = DEFAULT_GATE_DELAY
  )
`endif
(
  output logic q,
  output logic qbar,
  input  logic j,
  input  logic k,
  input  logic clock,
  input  logic clear
);

  // Active-low steering outputs: set, reset and toggle requests.
  logic set_n;
  logic rst_n;
  logic tog_n;
  logic q_core;
  logic armed;

`ifdef JK_LATCH_GATE_DELAY_EN
  assign #(GATE_DELAY) set_n = ~(clock & j & ~k);
  assign #(GATE_DELAY) rst_n = ~(clock & k & ~j);
  assign #(GATE_DELAY) tog_n = ~(clock & j & k);
  assign #(GATE_DELAY) q     = q_core;
  assign #(GATE_DELAY) qbar  = ~q_core;
`else
  assign set_n = ~(clock & j & ~k);
  assign rst_n = ~(clock & k & ~j);
  assign tog_n = ~(clock & j & k);
  assign q     = q_core;
  assign qbar  = ~q_core;
`endif

  // armed remembers that the current J=K=1 window already toggled, which
  // suppresses race-around while the latch stays transparent.
  always_latch begin
    if (clear) begin
      q_core <= Q_RESET;
      armed  <= 1'b0;
    end else if (!tog_n) begin
      if (!armed) begin
        q_core <= ~q_core;
        armed  <= 1'b1;
      end
    end else begin
      armed <= 1'b0;
      if (!set_n) begin
        q_core <= 1'b1;
      end else if (!rst_n) begin
        q_core <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jk_latch_gates.sv
`timescale 1ns/1ps
// WIDTH-bit bank of independent level-sensitive JK latches with asynchronous clear.
// Define JK_LATCH_GATE_DELAY_EN for per-gate #GATE_DELAY timing.
module jk_latch_gates
  import jk_latch_pkg::*;
#(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned GATE_DELAY = DEFAULT_GATE_DELAY
) (
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clock,
  input  logic             clear
);

  if (settle_time(GATE_DELAY) > 32'd65535) begin : g_gate_delay_range
    $error("jk_latch_gates: GATE_DELAY too large");
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_latch_bit
`ifdef JK_LATCH_GATE_DELAY_EN
        #(.GATE_DELAY(GATE_DELAY))
`endif
        u_bit (
          .q     (q[gi]),
          .qbar  (qbar[gi]),
          .j     (j[gi]),
          .k     (k[gi]),
          .clock (clock),
          .clear (clear)
        );
    end
  endgenerate

endmodule

// File: tb/tb_jk_latch_gates.sv
`timescale 1ns/1ps
// Self-checking bench for jk_latch_gates (WIDTH=4): directed vector table,
// hand-written corner sequences, and randomized steps against an arm-event model.
module tb_jk_latch_gates;
  import jk_latch_pkg::*;

  localparam int W      = 4;
  localparam int GD     = DEFAULT_GATE_DELAY;
  localparam int SETTLE = SETTLE_GATES * GD;

  logic [W-1:0] q, qbar, j, k;
  logic         clock, clear;

  int total = 0;
  int bad   = 0;

  jk_latch_gates #(.WIDTH(W), .GATE_DELAY(GD)) dut (
    .q     (q),
    .qbar  (qbar),
    .j     (j),
    .k     (k),
    .clock (clock),
    .clear (clear)
  );

  typedef struct {
    logic         clk;
    logic         clr;
    logic [W-1:0] jv;
    logic [W-1:0] kv;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: q=%h at t=%0t", name, act, $time);
    end
  endtask

  task automatic drive(input logic c, input logic cl, input logic [W-1:0] jj, input logic [W-1:0] kk);
    clock = c;
    clear = cl;
    j     = jj;
    k     = kk;
    #(SETTLE);
  endtask

  // Reference state for the random phase.
  logic [W-1:0] mq;
  logic         p_clk, p_clr;
  logic [W-1:0] p_j, p_k;

  initial begin
    logic         r_clk, r_clr;
    logic [W-1:0] r_j, r_k;
    logic         window_open;

    clock = 1'b1; clear = 1'b1; j = '0; k = '0;

    vecs[0]  = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0};  // reset
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0};  // release, hold 0
    vecs[2]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'hF};  // set
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'hF};  // hold
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 4'h0, 4'hF};
    vecs[5]  = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h0};  // rising clock toggles
    vecs[6]  = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h0};  // no second toggle
    vecs[7]  = '{1'b0, 1'b0, 4'hF, 4'hF, 4'h0};
    vecs[8]  = '{1'b1, 1'b0, 4'hF, 4'hF, 4'hF};  // next rising toggles back
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 4'hF, 4'h0};  // reset request
    vecs[10] = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h0};  // opaque: ignored
    vecs[11] = '{1'b1, 1'b0, 4'hF, 4'h0, 4'hF};  // transparent again
    vecs[12] = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0};  // clear mid-high
    vecs[13] = '{1'b1, 1'b0, 4'hA, 4'h5, 4'hA};  // independent bits
    vecs[14] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h5};  // j&k rises while high
    vecs[15] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h5};
    vecs[16] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h5};
    vecs[17] = '{1'b1, 1'b0, 4'h3, 4'h3, 4'h6};  // toggle bits 0,1 only
    vecs[18] = '{1'b1, 1'b0, 4'hC, 4'hC, 4'hA};  // toggle bits 2,3 only
    vecs[19] = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0};  // clear while opaque

    #1;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].clk, vecs[i].clr, vecs[i].jv, vecs[i].kv);
      check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
      check($sformatf("vec%0d_qbar", i), qbar, ~vecs[i].exp_q);
    end

    // Held J=K=1 through a long transparent phase: exactly one toggle.
    drive(1'b1, 1'b0, 4'hF, 4'h0);
    drive(1'b0, 1'b0, 4'hF, 4'hF);
    clock = 1'b1;
    #(SETTLE);
    for (int t = 0; t < 10; t++) begin
      check($sformatf("no_osc_%0d", t), q, 4'h0);
      #1;
    end

    // Clear coincident with rising clock: clear wins.
    drive(1'b0, 1'b0, 4'hF, 4'h0);
    clock = 1'b1; clear = 1'b1;
    #(SETTLE);
    check("clear_vs_rise", q, 4'h0);
    drive(1'b1, 1'b0, 4'hF, 4'h0);
    check("after_clear_set", q, 4'hF);
    // j/k change coincident with rising clock uses new values.
    drive(1'b0, 1'b0, 4'hF, 4'h0);
    clock = 1'b1; j = 4'h0; k = 4'h9;
    #(SETTLE);
    check("jk_with_rise", q, 4'h6);

    // Random phase against an arm-event model.
    drive(1'b0, 1'b1, 4'h0, 4'h0);
    mq = '0; p_clk = 1'b0; p_clr = 1'b1; p_j = '0; p_k = '0;
    for (int s = 0; s < 300; s++) begin
      r_clk = 1'($urandom_range(0, 1));
      r_clr = ($urandom_range(0, 15) == 0);
      r_j   = W'($urandom_range(0, 15));
      r_k   = W'($urandom_range(0, 15));
      drive(r_clk, r_clr, r_j, r_k);
      for (int b = 0; b < W; b++) begin
        window_open = p_clk && p_j[b] && p_k[b] && !p_clr;
        if (r_clr)                       mq[b] = 1'b0;
        else if (r_clk) begin
          if (r_j[b] && !r_k[b])         mq[b] = 1'b1;
          else if (!r_j[b] && r_k[b])    mq[b] = 1'b0;
          else if (r_j[b] && r_k[b] && !window_open) mq[b] = ~mq[b];
        end
      end
      check($sformatf("rnd%0d_q", s), q, mq);
      check($sformatf("rnd%0d_qbar", s), qbar, ~mq);
      p_clk = r_clk; p_clr = r_clr; p_j = r_j; p_k = r_k;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
